// File: rtl/input_buf_sched.sv
// Frame load/drain scheduler: streams one frame into an external buffer, then reads it back
// through a 2-entry output FIFO that hides the buffer's one-cycle read latency.

module input_buf_sched_chk #(
    parameter int DATA_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  abort,
    input logic                  in_ready,
    input logic                  busy,
    input logic                  buf_wr_en,
    input logic                  buf_rd_en,
    input logic                  out_valid,
    input logic                  out_ready,
    input logic                  done,
    input logic [DATA_WIDTH-1:0] out_data
);

    a_no_wr_rd: assert property (@(posedge clk) disable iff (!rst_n)
        !(buf_wr_en && buf_rd_en));

    a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready |-> busy);

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !abort) |=> (out_valid && (out_data == $past(out_data))));

    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

endmodule

module input_buf_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         buf_wr_en,
    output logic [ADDR_WIDTH-1:0]        buf_wr_addr,
    output logic [DATA_WIDTH-1:0]        buf_wr_data,
    output logic                         buf_rd_en,
    output logic [ADDR_WIDTH-1:0]        buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]        buf_rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One extra pointer bit so a full 2**ADDR_WIDTH frame can count to FRAME_LEN.
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] FRAME_LEN_C = PW'(FRAME_LEN);
    localparam logic [PW-1:0] LAST_IDX_C  = PW'(FRAME_LEN - 1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [DATA_WIDTH-1:0]   fifo_data_r [2];
    logic [1:0]              fifo_last_r;
    logic                    head_r;
    logic [1:0]              count_r;
    logic                    inflight_r;
    logic                    inflight_last_r;

    logic                    wr_fire_s;
    logic                    rd_fire_s;
    logic                    out_hs_s;
    logic [1:0]              occ_s;
    logic                    tail_s;
    logic                    head_last_s;

    // Buffer strobe qualification and FIFO occupancy bookkeeping.
    always_comb begin
        wr_fire_s   = 1'b0;
        rd_fire_s   = 1'b0;
        out_hs_s    = (count_r != 2'd0) && out_ready;
        occ_s       = count_r + {1'b0, inflight_r} - {1'b0, out_hs_s};
        tail_s      = head_r ^ count_r[0];
        head_last_s = fifo_last_r[head_r];
        if (abort) begin
            wr_fire_s = 1'b0;
            rd_fire_s = 1'b0;
        end else if (state_r == ST_LOAD) begin
            wr_fire_s = in_valid;
        end else if (state_r == ST_DRAIN) begin
            // A handshake this cycle frees a slot, so the read may overlap the pop.
            rd_fire_s = (rd_ptr_r < FRAME_LEN_C) && (occ_s < 2'd2);
        end else begin
            wr_fire_s = 1'b0;
            rd_fire_s = 1'b0;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_nxt_s = ST_LOAD;
                    else       state_nxt_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (wr_fire_s && (wr_ptr_r == LAST_IDX_C)) state_nxt_s = ST_DRAIN;
                    else                                        state_nxt_s = ST_LOAD;
                end
                ST_DRAIN: begin
                    if (out_hs_s && head_last_s) state_nxt_s = ST_DONE;
                    else                         state_nxt_s = ST_DRAIN;
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers, read-in-flight tracking and the 2-entry output FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r        <= {PW{1'b0}};
            rd_ptr_r        <= {PW{1'b0}};
            head_r          <= 1'b0;
            count_r         <= 2'd0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            fifo_last_r     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (abort) begin
            wr_ptr_r        <= {PW{1'b0}};
            rd_ptr_r        <= {PW{1'b0}};
            head_r          <= 1'b0;
            count_r         <= 2'd0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            fifo_last_r     <= 2'b00;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_IDX_C) ? {PW{1'b0}} : (wr_ptr_r + PW'(1));
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else if (state_r == ST_DONE) begin
                rd_ptr_r <= {PW{1'b0}};
            end
            inflight_r      <= rd_fire_s;
            inflight_last_r <= rd_fire_s && (rd_ptr_r == LAST_IDX_C);
            if (inflight_r) begin
                fifo_data_r[tail_s] <= buf_rd_data;
                fifo_last_r[tail_s] <= inflight_last_r;
            end
            if (out_hs_s) begin
                head_r <= ~head_r;
            end
            count_r <= occ_s;
        end
    end

    // Output decode; data buses read as zero whenever their strobe/valid is low.
    always_comb begin
        in_ready    = (state_r == ST_LOAD) && !abort;
        buf_wr_en   = wr_fire_s;
        buf_wr_addr = wr_ptr_r[ADDR_WIDTH-1:0];
        buf_wr_data = wr_fire_s ? in_data : {DATA_WIDTH{1'b0}};
        buf_rd_en   = rd_fire_s;
        buf_rd_addr = rd_ptr_r[ADDR_WIDTH-1:0];
        out_valid   = (count_r != 2'd0);
        out_data    = out_valid ? fifo_data_r[head_r] : {DATA_WIDTH{1'b0}};
        out_last    = out_valid && head_last_s;
        busy        = (state_r != ST_IDLE);
        done        = (state_r == ST_DONE);
    end

    input_buf_sched_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_ready  (in_ready),
        .busy      (busy),
        .buf_wr_en (buf_wr_en),
        .buf_rd_en (buf_rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_input_buf_sched.sv
// Bench for input_buf_sched: a behavioural buffer memory plus per-frame expected-word
// tables; one instance with a full-address-space frame of 4 words, one with a 1-word frame.
`timescale 1ns/1ps
module tb_input_buf_sched;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int FL = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_ready, buf_wr_en, buf_rd_en, out_valid, out_last, busy, done;
    logic [AW-1:0]        buf_wr_addr, buf_rd_addr;
    logic [DW-1:0]        buf_wr_data, out_data;
    logic [DW-1:0]        buf_rd_data = '0;
    logic [DW-1:0]        mem [FL];

    logic                 start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic signed [DW-1:0] in_data1 = '0;
    logic                 in_ready1, buf_wr_en1, buf_rd_en1, out_valid1, out_last1, busy1, done1;
    logic [0:0]           buf_wr_addr1, buf_rd_addr1;
    logic [DW-1:0]        buf_wr_data1, out_data1;
    logic [DW-1:0]        buf_rd_data1 = '0;
    logic [DW-1:0]        mem1 = '0;

    logic signed [DW-1:0] frame_w [FL];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_buf_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done));

    input_buf_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .buf_wr_en(buf_wr_en1), .buf_wr_addr(buf_wr_addr1), .buf_wr_data(buf_wr_data1),
        .buf_rd_en(buf_rd_en1), .buf_rd_addr(buf_rd_addr1), .buf_rd_data(buf_rd_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1), .done(done1));

    // Buffer memories with one-cycle read latency; garbage on the bus when not reading.
    always @(posedge clk) begin
        if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
        buf_rd_data <= buf_rd_en ? mem[buf_rd_addr] : DW'($urandom);
        if (buf_wr_en1) mem1 <= buf_wr_data1;
        buf_rd_data1 <= buf_rd_en1 ? mem1 : DW'($urandom);
    end

    task automatic check_quiet(input string tag);
        checks++;
        if ({in_ready, buf_wr_en, buf_rd_en, out_valid, out_last, busy, done} !== 7'b0 ||
            buf_wr_addr !== '0 || buf_wr_data !== '0 || buf_rd_addr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL %s: ctrl=%b wa=%h wd=%h ra=%h od=%h, required all zero", tag,
                     {in_ready, buf_wr_en, buf_rd_en, out_valid, out_last, busy, done},
                     buf_wr_addr, buf_wr_data, buf_rd_addr, out_data);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 16'sh1234; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); check_quiet("reset_held");
        #1 rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1 in_data = DW'($urandom); @(negedge clk); check_quiet("after_reset"); end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    // vmode: 0 back-to-back, 1 toggling, 2 random. rmode: 0 always ready, 1 random, 2 five-cycle stall.
    task automatic do_frame(input int vmode, input int rmode, input string tag);
        int idx, oidx, dc, issued, popped, guard;
        logic held_v;
        logic [DW-1:0] held_d;
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s idle_busy: busy=%b required 0", tag, busy); end
        @(posedge clk); #1 start = 1'b0;
        idx = 0; guard = 0;
        while (idx < FL && guard < 200) begin
            case (vmode)
                0: in_valid = 1'b1;
                1: in_valid = (guard % 2 == 0);
                default: in_valid = 1'($urandom_range(1));
            endcase
            in_data = in_valid ? frame_w[idx] : DW'($urandom);
            start = 1'($urandom_range(1));
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || buf_rd_en !== 1'b0 || buf_wr_en !== in_valid) begin
                errors++;
                $display("FAIL %s load_ctrl: rdy=%b busy=%b rd=%b wr=%b required 1 1 0 %b",
                         tag, in_ready, busy, buf_rd_en, buf_wr_en, in_valid);
            end
            if (in_valid) begin
                checks++;
                if (buf_wr_addr !== AW'(idx) || buf_wr_data !== frame_w[idx]) begin
                    errors++;
                    $display("FAIL %s write: addr=%0d data=%h required %0d %h",
                             tag, buf_wr_addr, buf_wr_data, idx, frame_w[idx]);
                end
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (idx != FL) begin errors++; $display("FAIL %s load_timeout: wrote %0d required %0d", tag, idx, FL); end
        in_valid = 1'b0;
        oidx = 0; dc = 0; issued = 0; popped = 0; held_v = 1'b0; held_d = '0;
        while (oidx < FL && dc < 300) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(1));
                default: out_ready = !(dc >= 3 && dc < 8);
            endcase
            in_valid = 1'($urandom_range(1));
            start = 1'($urandom_range(1));
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || buf_wr_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s drain_ctrl: rdy=%b wr=%b busy=%b done=%b required 0 0 1 0",
                         tag, in_ready, buf_wr_en, busy, done);
            end
            if (rmode == 0) begin
                checks++;
                if (out_valid !== (dc >= 2 && dc < 2 + FL) || buf_rd_en !== (dc < FL)) begin
                    errors++;
                    $display("FAIL %s throughput: cycle %0d valid=%b rd=%b required %b %b", tag, dc,
                             out_valid, buf_rd_en, (dc >= 2 && dc < 2 + FL), (dc < FL));
                end
            end
            if (buf_rd_en) begin
                checks++;
                if (buf_rd_addr !== AW'(issued) || issued >= FL ||
                    (issued - popped - int'(out_valid && out_ready)) >= 2) begin
                    errors++;
                    $display("FAIL %s read_issue: addr=%0d issued=%0d popped=%0d required addr %0d, <2 held",
                             tag, buf_rd_addr, issued, popped, issued);
                end
                issued++;
            end
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_d) begin
                    errors++;
                    $display("FAIL %s hold_stable: valid=%b data=%h required 1 %h", tag, out_valid, out_data, held_d);
                end
            end
            if (out_valid) begin
                checks++;
                if (out_data !== frame_w[oidx] || out_last !== (oidx == FL - 1)) begin
                    errors++;
                    $display("FAIL %s out_word %0d: data=%h last=%b required %h %b",
                             tag, oidx, out_data, out_last, frame_w[oidx], (oidx == FL - 1));
                end
                if (out_ready) begin oidx++; popped++; end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            @(posedge clk); #1;
            dc++;
        end
        out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
        checks++;
        if (oidx != FL) begin errors++; $display("FAIL %s drain_timeout: got %0d words required %0d", tag, oidx, FL); end
        @(negedge clk); checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || buf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b busy=%b valid=%b rd=%b required 1 1 0 0",
                     tag, done, busy, out_valid, buf_rd_en);
        end
        @(posedge clk); #1;
        @(negedge clk); checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: done=%b busy=%b required 0 0", tag, done, busy);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < FL; i++) frame_w[i] = DW'($urandom);
    endtask

    task automatic test_back_to_back();
        frame_w[0] = 16'sd10; frame_w[1] = -16'sd20; frame_w[2] = 16'sd30; frame_w[3] = -16'sd40;
        do_frame(0, 0, "back_to_back");
    endtask

    task automatic test_abort();
        fill_random();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < FL; i++) begin in_valid = 1'b1; in_data = frame_w[i]; @(posedge clk); #1; end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk); checks++;
        if (out_valid !== 1'b1 || out_data !== frame_w[2] || buf_rd_en !== 1'b0 || buf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle: valid=%b data=%h rd=%b wr=%b required 1 %h 0 0",
                     out_valid, out_data, buf_rd_en, buf_wr_en, frame_w[2]);
        end
        @(posedge clk); #1 abort = 1'b0;
        repeat (3) begin
            @(negedge clk); checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle: busy=%b valid=%b done=%b rdy=%b required 0 0 0 0",
                         busy, out_valid, done, in_ready);
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = 16'sh7777;
        @(posedge clk); #1 abort = 1'b1; in_data = 16'sh5555;
        @(negedge clk); checks++;
        if (buf_wr_en !== 1'b0) begin errors++; $display("FAIL abort_load_write: wr=%b required 0", buf_wr_en); end
        @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
        @(negedge clk); checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_load_idle: busy=%b required 0", busy); end
        fill_random();
        do_frame(0, 0, "after_abort");
    endtask

    task automatic test_reset_mid_load();
        fill_random();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 2; i++) begin in_valid = 1'b1; in_data = frame_w[i]; @(posedge clk); #1; end
        in_data = frame_w[2];
        #2 rst_n = 1'b0;
        #1 check_quiet("reset_mid_load");
        @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0;
        repeat (3) begin @(negedge clk); check_quiet("post_reset_idle"); @(posedge clk); #1; end
        fill_random();
        do_frame(2, 1, "after_reset");
    endtask

    task automatic test_single_word();
        logic [DW-1:0] w;
        w = DW'($urandom);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0; in_valid1 = 1'b1; in_data1 = w;
        @(negedge clk); checks++;
        if (buf_wr_en1 !== 1'b1 || buf_wr_addr1 !== 1'b0 || buf_wr_data1 !== w || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL single_write: wr=%b addr=%0d data=%h required 1 0 %h", buf_wr_en1, buf_wr_addr1, buf_wr_data1, w);
        end
        @(posedge clk); #1 in_valid1 = 1'b0; out_ready1 = 1'b1;
        @(negedge clk); checks++;
        if (buf_rd_en1 !== 1'b1 || buf_rd_addr1 !== 1'b0 || out_valid1 !== 1'b0 || buf_wr_en1 !== 1'b0) begin
            errors++;
            $display("FAIL single_read: rd=%b addr=%0d valid=%b required 1 0 0", buf_rd_en1, buf_rd_addr1, out_valid1);
        end
        @(posedge clk); #1;
        @(negedge clk); checks++;
        if (buf_rd_en1 !== 1'b0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL single_gap: rd=%b valid=%b required 0 0", buf_rd_en1, out_valid1);
        end
        @(posedge clk); #1;
        @(negedge clk); checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== w || out_last1 !== 1'b1) begin
            errors++;
            $display("FAIL single_out: valid=%b data=%h last=%b required 1 %h 1", out_valid1, out_data1, out_last1, w);
        end
        @(posedge clk); #1 out_ready1 = 1'b0;
        @(negedge clk); checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL single_done: done=%b busy=%b required 1 1", done1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        fill_random(); do_frame(1, 0, "toggle_valid");
        fill_random(); do_frame(2, 2, "stall");
        test_abort();
        test_reset_mid_load();
        for (int k = 0; k < 6; k++) begin fill_random(); do_frame(2, 1, "random"); end
        test_single_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
